sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Serial-in, parallel-out front end. Assembles N serial bits into one N-bit word and presents it with a valid/ready handshake.
- Sits directly upstream of the team's N-bit enabled storage register. That register's load enable is driven by dout_valid & dout_ready, and its D input by dout.
- Contains a one-word output buffer, so the next word can shift in while the current word waits to be consumed.

Parameters:
- N, 8, word width in bits; legal range is N >= 1.
- MSB_FIRST, 1: 1 means the first accepted bit lands in dout[N-1]; 0 means it lands in dout[0].

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- n_clr, input, 1, synchronous active-low clear.
- s_in, input, 1, serial data bit.
- s_valid, input, 1, s_in is valid this cycle.
- s_ready, output, 1, block accepts s_in this cycle. This output is combinational.
- dout, output, N, assembled parallel word. This is a registered output.
- dout_valid, output, 1, dout holds an unconsumed word. This is a registered output.
- dout_ready, input, 1, downstream consumes dout this cycle.
- bit_cnt, output, CW, number of bits accepted toward the current word. CW = max(1, $clog2(N)).

Behaviour:
- Reset (asynchronous, reset=1):
  - sr (internal shift register) = 0, bit_cnt = 0, dout = 0, dout_valid = 0.
  - While reset is held, s_ready = 0.
  - On the first rising clk edge after reset falls, s_ready = 1.
  - A reset that arrives mid-word discards the partial word and any buffered word.
- Accept condition: acc = s_valid & s_ready & n_clr.
- Input shift on acc:
  - MSB_FIRST=1: sr <= {sr[N-2:0], s_in}.
  - MSB_FIRST=0: sr <= {s_in, sr[N-1:1]}.
  - For N=1: sr <= s_in.
- Counter:
  - acc with bit_cnt < N-1: bit_cnt increments.
  - acc with bit_cnt == N-1 ("completing accept"): bit_cnt <= 0, and dout <= the shifted word including the current s_in.
  - No acc: bit_cnt and sr hold.
- Latency:
  - dout and dout_valid update on the same edge that samples the Nth bit.
  - The word is visible the cycle after that edge.
  - No bubble is needed between words; one bit per cycle is sustained when dout_ready=1.
- Output buffer FSM, two states:
  - EMPTY (dout_valid=0): a completing accept moves to FULL (dout_valid <= 1).
  - FULL (dout_valid=1): a handshake is dout_valid & dout_ready.
    - Handshake with no completing accept: go to EMPTY (dout_valid <= 0). dout holds its last value.
    - Handshake and completing accept in the same cycle: stay FULL, dout <= new word. The new word wins.
    - No handshake: dout and dout_valid hold. dout must stay stable while dout_valid=1 and dout_ready=0.
- Back-pressure:
  - s_ready = ~reset_sync_hold & n_clr & ~(dout_valid & ~dout_ready & bit_cnt == N-1).
  - Partial words keep filling while the buffer is FULL. Only the completing bit stalls.
  - s_ready is combinational from dout_ready, dout_valid and bit_cnt. It has no dependence on s_valid.
- n_clr=0 (synchronous), sampled on a rising edge:
  - sr = 0, bit_cnt = 0, dout = 0, dout_valid = 0.
  - s_ready = 0 and s_in is ignored.
  - n_clr overrides a simultaneous acc or handshake.
- Width rules:
  - bit_cnt wraps only through the completing accept. Values >= N never occur.
  - For N=1, bit_cnt is constant 0 and every acc is a completing accept.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
1. Reset, then MSB_FIRST=1, N=8, dout_ready=1, serial stream 1,0,1,1,0,0,1,0 on consecutive cycles -> dout=8'hB2 and dout_valid=1 for exactly 1 cycle, the cycle after the 8th bit. bit_cnt reads 0..7 then 0.
2. MSB_FIRST=0, same stream -> dout=8'h4D.
3. Back-pressure: dout_ready=0, stream bytes 8'hA5 then 8'h3C -> 7 bits of the 2nd byte are accepted. s_ready=0 with bit_cnt=7. dout holds 8'hA5. Raising dout_ready for 1 cycle -> 8'hA5 is consumed, the 8th bit is accepted in the same cycle, and the next cycle shows dout=8'h3C with dout_valid=1.
4. Back-to-back: continuous s_valid=1 for 24 cycles with dout_ready=1 -> three words on dout_valid at cycles 8, 16 and 24 after the start, with no stall (s_ready=1 throughout).
5. n_clr=0 for 1 cycle after 4 bits of a word, with a buffered word pending -> bit_cnt=0, dout_valid=0, dout=0. A fresh 8-bit stream afterwards yields the correct word with no residue.
6. Async reset asserted between clock edges mid-word -> outputs are zero immediately, without waiting for clk. After release, a full word assembles correctly. Repeat with N=1: every accepted bit produces dout=s_in and a dout_valid pulse.

Source files
------------

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: assembles N serial bits into a word and holds it in a
// one-word output buffer behind a valid/ready handshake.
module sipo_deserializer #(
    parameter int N = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          n_clr,
    input  logic          s_in,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [N-1:0]  dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [CW-1:0] bit_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state;
    logic [N-1:0] sr;
    logic [N-1:0] nxt;
    logic hold;
    logic last;
    logic acc;
    generate
        if (N == 1) begin : g_one
            assign nxt = s_in;
        end else if (MSB_FIRST) begin : g_msb
            assign nxt = {sr[N-2:0], s_in};
        end else begin : g_lsb
            assign nxt = {s_in, sr[N-1:1]};
        end
    endgenerate
    assign last = (bit_cnt == CW'(N - 1));
    assign dout_valid = (state == FULL);
    // Only the word-completing bit stalls on a full, unconsumed buffer.
    assign s_ready = ~hold & n_clr & ~(dout_valid & ~dout_ready & last);
    assign acc = s_valid & s_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
            dout    <= '0;
            state   <= EMPTY;
            hold    <= 1'b1;
        end else begin
            hold <= 1'b0;
            if (!n_clr) begin
                sr      <= '0;
                bit_cnt <= '0;
                dout    <= '0;
                state   <= EMPTY;
            end else begin
                if (acc) begin
                    sr      <= nxt;
                    bit_cnt <= last ? '0 : bit_cnt + 1'b1;
                end
                if (acc && last) begin
                    dout  <= nxt;
                    state <= FULL;
                end else if (dout_valid && dout_ready) begin
                    state <= EMPTY;
                end
            end
        end
    end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: three instances (N=8 MSB-first, N=8 LSB-first, N=1)
// share one stimulus and are checked every cycle against a bit-position model.
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic n_clr = 1'b1;
    logic s_in = 1'b0;
    logic s_valid = 1'b0;
    logic dout_ready = 1'b1;
    logic s_ready0, s_ready1, s_ready2;
    logic [7:0] dout0, dout1;
    logic [0:0] dout2;
    logic dout_valid0, dout_valid1, dout_valid2;
    logic [2:0] bit_cnt0, bit_cnt1;
    logic [0:0] bit_cnt2;
    int ncmp = 0;
    int nerr = 0;

    sipo_deserializer #(.N(8), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset), .n_clr(n_clr), .s_in(s_in), .s_valid(s_valid),
        .s_ready(s_ready0), .dout(dout0), .dout_valid(dout_valid0),
        .dout_ready(dout_ready), .bit_cnt(bit_cnt0));
    sipo_deserializer #(.N(8), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .n_clr(n_clr), .s_in(s_in), .s_valid(s_valid),
        .s_ready(s_ready1), .dout(dout1), .dout_valid(dout_valid1),
        .dout_ready(dout_ready), .bit_cnt(bit_cnt1));
    sipo_deserializer #(.N(1), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .reset(reset), .n_clr(n_clr), .s_in(s_in), .s_valid(s_valid),
        .s_ready(s_ready2), .dout(dout2), .dout_valid(dout_valid2),
        .dout_ready(dout_ready), .bit_cnt(bit_cnt2));

    always #5 clk = ~clk;

    // Model: bits are dropped straight into their final position of the word.
    int  ln[3]   = '{8, 8, 1};
    bit  lmsb[3] = '{1'b1, 1'b0, 1'b1};
    int  mcnt[3] = '{0, 0, 0};
    int  mword[3] = '{0, 0, 0};
    int  mbuf[3] = '{0, 0, 0};
    bit  mfull[3] = '{1'b0, 1'b0, 1'b0};
    bit  mhold = 1'b1;

    function automatic bit exp_rdy(input int l);
        return !mhold && n_clr && !(mfull[l] && !dout_ready && mcnt[l] == ln[l] - 1);
    endfunction

    initial begin
        bit ok, hs;
        forever begin
            @(posedge clk or posedge reset);
            for (int l = 0; l < 3; l++) begin
                ok = s_valid && exp_rdy(l);
                hs = mfull[l] && dout_ready;
                if (reset || !n_clr) begin
                    mcnt[l] = 0; mword[l] = 0; mbuf[l] = 0; mfull[l] = 1'b0;
                end else if (ok) begin
                    if (s_in) mword[l] = mword[l] | (1 << (lmsb[l] ? ln[l] - 1 - mcnt[l] : mcnt[l]));
                    mcnt[l]++;
                    if (mcnt[l] == ln[l]) begin
                        mbuf[l] = mword[l]; mfull[l] = 1'b1; mword[l] = 0; mcnt[l] = 0;
                    end else if (hs) mfull[l] = 1'b0;
                end else if (hs) mfull[l] = 1'b0;
            end
            mhold = reset;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("rdy0", 32'(s_ready0), 32'(exp_rdy(0)));
        chk("rdy1", 32'(s_ready1), 32'(exp_rdy(1)));
        chk("rdy2", 32'(s_ready2), 32'(exp_rdy(2)));
        chk("dout0", 32'(dout0), mbuf[0]);
        chk("dout1", 32'(dout1), mbuf[1]);
        chk("dout2", 32'(dout2), mbuf[2]);
        chk("vld0", 32'(dout_valid0), 32'(mfull[0]));
        chk("vld1", 32'(dout_valid1), 32'(mfull[1]));
        chk("vld2", 32'(dout_valid2), 32'(mfull[2]));
        chk("cnt0", 32'(bit_cnt0), mcnt[0]);
        chk("cnt1", 32'(bit_cnt1), mcnt[1]);
        chk("cnt2", 32'(bit_cnt2), mcnt[2]);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        s_valid = 1'b1;
        s_in = b;
        tick();
    endtask

    task automatic idle(input int k);
        s_valid = 1'b0;
        repeat (k) tick();
    endtask

    task automatic send_word(input logic [7:0] w, input int nb);
        for (int i = 0; i < nb; i++) send(w[7-i]);
    endtask

    initial begin
        logic [7:0] w;
        #8;
        chk("rst_dout", 32'(dout0), 0);
        chk("rst_vld", 32'(dout_valid0), 0);
        chk("rst_rdy", 32'(s_ready0), 0);
        #4 reset = 1'b0;
        #1 chk("hold_rdy", 32'(s_ready0), 0);
        @(posedge clk);
        #1 chk("rel_rdy", 32'(s_ready0), 1);
        // Basic word, both bit orders
        dout_ready = 1'b1;
        w = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            chk("t1_cnt", 32'(bit_cnt0), i);
            send(w[7-i]);
        end
        chk("t1_msb", 32'(dout0), 32'hB2);
        chk("t1_lsb", 32'(dout1), 32'h4D);
        chk("t1_vld", 32'(dout_valid0), 1);
        chk("t1_cnt_wrap", 32'(bit_cnt0), 0);
        idle(1);
        chk("t1_vld_pulse", 32'(dout_valid0), 0);
        // Back-pressure
        dout_ready = 1'b0;
        send_word(8'hA5, 8);
        send_word(8'h3C, 7);
        chk("t3_stall_rdy", 32'(s_ready0), 0);
        chk("t3_cnt7", 32'(bit_cnt0), 7);
        chk("t3_hold", 32'(dout0), 32'hA5);
        send(1'b0);
        chk("t3_hold2", 32'(dout0), 32'hA5);
        chk("t3_cnt_hold", 32'(bit_cnt0), 7);
        dout_ready = 1'b1;
        #1 chk("t3_rdy_up", 32'(s_ready0), 1);
        tick();
        chk("t3_new", 32'(dout0), 32'h3C);
        chk("t3_new_vld", 32'(dout_valid0), 1);
        idle(1);
        chk("t3_drain", 32'(dout_valid0), 0);
        // Back-to-back stream
        for (int i = 0; i < 24; i++) begin
            s_valid = 1'b1;
            s_in = 1'($urandom_range(1));
            chk("t4_rdy", 32'(s_ready0), 1);
            tick();
            chk("t4_vld", 32'(dout_valid0), 32'(((i + 1) % 8) == 0));
        end
        idle(1);
        // Synchronous clear with a buffered word and a partial word
        dout_ready = 1'b0;
        send_word(8'h5A, 8);
        send_word(8'hF0, 4);
        chk("t5_pend", 32'(dout_valid0), 1);
        chk("t5_cnt4", 32'(bit_cnt0), 4);
        n_clr = 1'b0;
        s_valid = 1'b1;
        s_in = 1'b1;
        #1 chk("t5_clr_rdy", 32'(s_ready0), 0);
        tick();
        chk("t5_cnt", 32'(bit_cnt0), 0);
        chk("t5_vld", 32'(dout_valid0), 0);
        chk("t5_dout", 32'(dout0), 0);
        n_clr = 1'b1;
        dout_ready = 1'b1;
        send_word(8'hC3, 8);
        chk("t5_fresh", 32'(dout0), 32'hC3);
        chk("t5_fresh_lsb", 32'(dout1), 32'hC3);
        // Asynchronous reset mid-word
        dout_ready = 1'b0;
        send_word(8'hE0, 3);
        chk("t6_pre_dout", 32'(dout0), 32'hC3);
        chk("t6_pre_cnt", 32'(bit_cnt0), 3);
        #2 reset = 1'b1;
        s_valid = 1'b0;
        #1;
        chk("t6_dout", 32'(dout0), 0);
        chk("t6_vld", 32'(dout_valid0), 0);
        chk("t6_cnt", 32'(bit_cnt0), 0);
        chk("t6_rdy", 32'(s_ready0), 0);
        tick();
        #2 reset = 1'b0;
        #1 chk("t6_hold", 32'(s_ready0), 0);
        tick();
        chk("t6_rel", 32'(s_ready0), 1);
        dout_ready = 1'b1;
        send_word(8'h96, 8);
        chk("t6_word", 32'(dout0), 32'h96);
        chk("t6_word_lsb", 32'(dout1), 32'h69);
        send(1'b1);
        chk("n1_d1", 32'(dout2), 1);
        chk("n1_v1", 32'(dout_valid2), 1);
        send(1'b0);
        chk("n1_d0", 32'(dout2), 0);
        chk("n1_v0", 32'(dout_valid2), 1);
        chk("n1_cnt", 32'(bit_cnt2), 0);
        idle(2);
        chk("n1_idle", 32'(dout_valid2), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
